// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard logic.
//   hz_tag_t       : {valid, rd} tag mirroring one pipeline stage's destination
//   REG_ZERO       : architectural zero register index
//   NUM_TAG_STAGES : number of tracked stages (E, M, W)
//   tag_hit()      : true when a valid tag writes the given register
package pipeline_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } hz_tag_t;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         NUM_TAG_STAGES = 3;

  function automatic logic tag_hit(input hz_tag_t tag, input logic [4:0] rs);
    return tag.valid && (tag.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// E/M/W destination-tag shift register.
//   clk_i, rst_ni : clock, asynchronous active-low reset (invalidates all tags)
//   clear         : load an invalid tag into E (bubble)
//   rd, reg_write : destination of the instruction leaving decode
//   tag_e/m/w     : current tags of the E, M and W stages
module hazard_tag_pipe
  import pipeline_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear,
  input  logic [4:0] rd,
  input  logic       reg_write,
  output hz_tag_t    tag_e,
  output hz_tag_t    tag_m,
  output hz_tag_t    tag_w
);

  hz_tag_t tag_reg [NUM_TAG_STAGES];
  hz_tag_t tag_next;

  // Writes to x0 are architecturally discarded, so they never form a tag.
  always_comb begin
    tag_next.valid = reg_write && (rd != REG_ZERO) && !clear;
    tag_next.rd    = rd;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_reg[0] <= '0;
    end else begin
      tag_reg[0] <= tag_next;
    end
  end

  // Later stages advance unconditionally; the pipeline never holds E/M/W.
  generate
    for (genvar gi = 1; gi < NUM_TAG_STAGES; gi++) begin : g_stage
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          tag_reg[gi] <= '0;
        end else begin
          tag_reg[gi] <= tag_reg[gi-1];
        end
      end
    end
  endgenerate

  assign tag_e = tag_reg[0];
  assign tag_m = tag_reg[1];
  assign tag_w = tag_reg[2];

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard detector and pipeline control for an in-order 5-stage core.
//   WB_BYPASS   : 1 = register file writes through, W stage never hazards
//   CNT_W       : width of the saturating performance counters
//   clk_i/rst_ni: clock, asynchronous active-low reset
//   rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID : decode-stage sources
//   rd_ID, reg_write_ID : decode-stage destination
//   redirect_EX : taken branch/jump resolved in execute
//   stall_IF, stall_ID, clear_EX, flush_ID : pipeline controls
//   stall_cnt_o : cycles spent stalling on RAW hazards
//   flush_cnt_o : cycles spent flushing for redirects
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int WB_BYPASS = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_ID,
  input  logic             reg_write_ID,
  input  logic             redirect_EX,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             clear_EX,
  output logic             flush_ID,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  hz_tag_t tag_e;
  hz_tag_t tag_m;
  hz_tag_t tag_w;

  hazard_tag_pipe u_tag_pipe (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear     (clear_EX),
    .rd        (rd_ID),
    .reg_write (reg_write_ID),
    .tag_e     (tag_e),
    .tag_m     (tag_m),
    .tag_w     (tag_w)
  );

  // W only matters when the register file cannot forward a same-cycle write.
  localparam logic W_CHECK = (WB_BYPASS == 0);

  logic match_1;
  logic match_2;
  logic raw;

  always_comb begin
    match_1 = rs1_used_ID && (rs1_ID != REG_ZERO) &&
              (tag_hit(tag_e, rs1_ID) || tag_hit(tag_m, rs1_ID) ||
               (W_CHECK && tag_hit(tag_w, rs1_ID)));
    match_2 = rs2_used_ID && (rs2_ID != REG_ZERO) &&
              (tag_hit(tag_e, rs2_ID) || tag_hit(tag_m, rs2_ID) ||
               (W_CHECK && tag_hit(tag_w, rs2_ID)));
    raw     = match_1 || match_2;
  end

  // A redirect kills the decode instruction anyway, so it wins over a stall.
  always_comb begin
    stall_IF = 1'b0;
    stall_ID = 1'b0;
    clear_EX = 1'b0;
    flush_ID = 1'b0;
    if (redirect_EX) begin
      flush_ID = 1'b1;
      clear_EX = 1'b1;
    end else if (raw) begin
      stall_IF = 1'b1;
      stall_ID = 1'b1;
      clear_EX = 1'b1;
    end
  end

  // Saturating counters: index 0 = stall cycles, index 1 = flush cycles.
  logic             cnt_inc [2];
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_inc[0] = stall_ID;
  assign cnt_inc[1] = flush_ID;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cnt_o = cnt_reg[0];
  assign flush_cnt_o = cnt_reg[1];

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (no bypass / 16-bit counters and
// write-through / 3-bit counters) share one stimulus stream and are checked
// each cycle against a reference model that tracks, per instance, which
// registers the three in-flight instructions ahead of decode will write.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        u1 = 1'b0, u2 = 1'b0, rw = 1'b0, redir = 1'b0;

  logic        s_if0, s_id0, c_ex0, f_id0;
  logic        s_if1, s_id1, c_ex1, f_id1;
  logic [15:0] sc0, fc0;
  logic [2:0]  sc1, fc1;

  always #5 clk = ~clk;

  hazard_scoreboard #(.WB_BYPASS(0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_ID(rs1), .rs2_ID(rs2), .rs1_used_ID(u1), .rs2_used_ID(u2),
    .rd_ID(rd), .reg_write_ID(rw), .redirect_EX(redir),
    .stall_IF(s_if0), .stall_ID(s_id0), .clear_EX(c_ex0), .flush_ID(f_id0),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .rs1_ID(rs1), .rs2_ID(rs2), .rs1_used_ID(u1), .rs2_used_ID(u2),
    .rd_ID(rd), .reg_write_ID(rw), .redirect_EX(redir),
    .stall_IF(s_if1), .stall_ID(s_id1), .clear_EX(c_ex1), .flush_ID(f_id1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: pending writers ahead of decode, youngest first (-1 = none).
  int ahead [2][3];
  int exp_sc [2];
  int exp_fc [2];
  int cmax   [2] = '{65535, 7};
  int depth  [2] = '{3, 2};   // stages whose writes are not yet readable
  bit ex_stall [2];
  bit ex_flush [2];
  int seen_stall [2];

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit depends(int k, logic [4:0] r, logic used);
    if (!used || r == 5'd0) return 1'b0;
    for (int i = 0; i < depth[k]; i++)
      if (ahead[k][i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) ahead[k][i] = -1;
      exp_sc[k] = 0;
      exp_fc[k] = 0;
    end
  endtask

  task automatic model_eval();
    for (int k = 0; k < 2; k++) begin
      ex_flush[k] = redir;
      ex_stall[k] = !redir && (depends(k, rs1, u1) || depends(k, rs2, u2));
    end
  endtask

  // One clock: the decode instruction moves ahead unless it was squashed.
  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      ahead[k][2] = ahead[k][1];
      ahead[k][1] = ahead[k][0];
      if (ex_stall[k] || ex_flush[k] || !rw || rd == 5'd0) ahead[k][0] = -1;
      else ahead[k][0] = int'(rd);
      if (ex_stall[k] && exp_sc[k] < cmax[k]) exp_sc[k]++;
      if (ex_flush[k] && exp_fc[k] < cmax[k]) exp_fc[k]++;
    end
  endtask

  task automatic check_outputs();
    check_val("stall_IF0", s_if0, ex_stall[0]);
    check_val("stall_ID0", s_id0, ex_stall[0]);
    check_val("clear_EX0", c_ex0, ex_stall[0] || ex_flush[0]);
    check_val("flush_ID0", f_id0, ex_flush[0]);
    check_val("stall_IF1", s_if1, ex_stall[1]);
    check_val("stall_ID1", s_id1, ex_stall[1]);
    check_val("clear_EX1", c_ex1, ex_stall[1] || ex_flush[1]);
    check_val("flush_ID1", f_id1, ex_flush[1]);
    check_val("stall_cnt0", sc0, exp_sc[0]);
    check_val("flush_cnt0", fc0, exp_fc[0]);
    check_val("stall_cnt1", sc1, exp_sc[1]);
    check_val("flush_cnt1", fc1, exp_fc[1]);
  endtask

  task automatic set_in(input int a, input bit ua, input int b, input bit ub,
                        input int d, input bit w, input bit r);
    rs1 = a[4:0]; u1 = ua; rs2 = b[4:0]; u2 = ub;
    rd = d[4:0]; rw = w; redir = r;
  endtask

  // Called at posedge+1; checks at negedge, then advances one clock.
  task automatic step();
    model_eval();
    @(negedge clk);
    check_outputs();
    seen_stall[0] += int'(s_id0);
    seen_stall[1] += int'(s_id1);
    $display("cyc %0d rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b redir=%0b | d0 st=%0b fl=%0b sc=%0d fc=%0d | d1 st=%0b fl=%0b sc=%0d fc=%0d",
             cyc, rs1, u1, rs2, u2, rd, rw, redir, s_id0, f_id0, sc0, fc0,
             s_id1, f_id1, sc1, fc1);
    @(posedge clk);
    model_clock();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_stall_ID0", s_id0, 0);
    check_val("rst_clear_EX1", c_ex1, 0);
    check_val("rst_stall_cnt0", sc0, 0);
    check_val("rst_flush_cnt1", fc1, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sc_before, fc_before;
    model_reset();
    for (int k = 0; k < 2; k++) seen_stall[k] = 0;
    #2;
    do_reset();

    // Producer x5 then "add x6,x5,x1", consumer held while stalled.
    set_in(0, 0, 0, 0, 5, 1, 0);
    step();
    seen_stall[0] = 0; seen_stall[1] = 0;
    set_in(5, 1, 1, 1, 6, 1, 0);
    for (int i = 0; i < 4; i++) step();
    check_val("dep_stall_cycles_nobyp", seen_stall[0], 3);
    check_val("dep_stall_cycles_byp", seen_stall[1], 2);
    idle(3);
    check_val("dep_stall_cnt_nobyp", sc0, 3);
    check_val("dep_stall_cnt_byp", sc1, 2);

    // Writes to x0 never create a tag; reads of x0 never stall.
    set_in(0, 0, 0, 0, 0, 1, 0);
    step();
    check_val("x0_tagE_valid", dut0.tag_e.valid, 0);
    sc_before = exp_sc[0];
    seen_stall[0] = 0;
    set_in(0, 1, 0, 1, 7, 1, 0);
    step();
    step();
    check_val("x0_no_stall", seen_stall[0], 0);
    idle(3);

    // Redirect coincident with a RAW hazard counts as a flush only.
    set_in(0, 0, 0, 0, 5, 1, 0);
    step();
    sc_before = int'(sc0);
    fc_before = int'(fc0);
    set_in(5, 1, 0, 0, 6, 1, 1);
    step();
    idle(1);
    check_val("redir_flush_cnt", fc0, fc_before + 1);
    check_val("redir_stall_cnt", sc0, sc_before);
    idle(2);

    // Drive the 3-bit counter of the bypass instance into saturation.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      set_in(0, 0, 0, 0, 5, 1, 0);
      step();
      set_in(0, 0, 5, 1, 6, 1, 0);
      for (int i = 0; i < 3; i++) step();
      idle(3);
    end
    check_val("sat_stall_cnt_byp", sc1, 7);
    check_val("sat_stall_cnt_nobyp", sc0, 12);

    // Asynchronous reset in the second stall cycle.
    set_in(0, 0, 0, 0, 5, 1, 0);
    step();
    set_in(5, 1, 1, 1, 6, 1, 0);
    step();
    model_eval();
    @(negedge clk);
    check_val("mid_stall_before_rst", s_id0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_stall_ID0", s_id0, 0);
    check_val("mid_rst_stall_ID1", s_id1, 0);
    check_val("mid_rst_stall_IF0", s_if0, 0);
    check_val("mid_rst_clear_EX0", c_ex0, 0);
    check_val("mid_rst_stall_cnt0", sc0, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    seen_stall[0] = 0; seen_stall[1] = 0;
    set_in(7, 1, 8, 1, 9, 1, 0);
    step();
    idle(1);
    check_val("post_rst_stalls0", seen_stall[0], 0);
    check_val("post_rst_stalls1", seen_stall[1], 0);

    // Randomised traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_in(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));
      step();
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
